tr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 16-bit temp-register subsystem. Shares the single TR write port among five requesters (datapath sources a..e) by driving `tr_src` and `tr_write` into the TR mux/register pair. Supports single-cycle writes and locked multi-cycle ownership, with a bounded lock timeout. Sits in the control path between the requesting units and the TR subsystem.

---
 rtl/tr_arbiter.sv | 130 +++++++++++++
 tb/tb_tr_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/tr_arbiter.sv
// Round-robin arbiter for the five TR write-port requesters. It issues one-cycle grants
// and supports locked ownership, which is forcibly released after MAX_LOCK cycles.
module tr_arbiter #(
  parameter int MAX_LOCK = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic [4:0] lock,
  input  logic       err_clr,
  output logic [4:0] gnt,
  output logic       tr_write,
  output logic [2:0] tr_src,
  output logic       busy,
  output logic       lock_err
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t     state_reg, state_next;
  logic [4:0] gnt_reg, gnt_next;
  logic       tr_write_reg, tr_write_next;
  logic [2:0] tr_src_reg, tr_src_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       lock_err_reg, lock_err_next;

  logic [4:0] eligible;
  logic       found;
  logic [2:0] win;
  logic [3:0] sum;
  logic       do_arb;
  logic       err_set;

  // The current holder's bit is masked so that one requester cannot take two grants back to back.
  assign eligible = req & ~gnt_reg;

  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    sum   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr_reg} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      if (!found && eligible[sum[2:0]]) begin
        found = 1'b1;
        win   = sum[2:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= 5'd0;
      tr_write_reg <= 1'b0;
      tr_src_reg   <= 3'd0;
      ptr_reg      <= 3'd0;
      cnt_reg      <= 8'd0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      tr_write_reg <= tr_write_next;
      tr_src_reg   <= tr_src_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      lock_err_reg <= lock_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    tr_write_next = 1'b0;
    tr_src_next   = tr_src_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    do_arb        = 1'b0;
    err_set       = 1'b0;
    case (state_reg)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (lock[tr_src_reg]) begin
          state_next    = LOCKED;
          tr_write_next = req[tr_src_reg];
          cnt_next      = 8'd1;
        end else begin
          do_arb = 1'b1;
        end
      end
      LOCKED: begin
        // A lock drop takes priority over the timeout, so a coincident drop never flags an error.
        if (!lock[tr_src_reg]) begin
          do_arb = 1'b1;
        end else if (cnt_reg == 8'(MAX_LOCK)) begin
          do_arb  = 1'b1;
          err_set = 1'b1;
        end else begin
          cnt_next      = cnt_reg + 8'd1;
          tr_write_next = req[tr_src_reg];
        end
      end
      default: do_arb = 1'b1;
    endcase
    if (do_arb) begin
      cnt_next = 8'd0;
      if (found) begin
        state_next    = GRANT;
        gnt_next      = 5'(5'b00001 << win);
        tr_write_next = 1'b1;
        tr_src_next   = win;
        ptr_next      = (win == 3'd4) ? 3'd0 : win + 3'd1;
      end else begin
        state_next = IDLE;
        gnt_next   = 5'd0;
      end
    end
    lock_err_next = err_clr ? 1'b0 : (lock_err_reg | err_set);
  end

  always_comb begin
    gnt      = gnt_reg;
    tr_write = tr_write_reg;
    tr_src   = tr_src_reg;
    busy     = (state_reg != IDLE);
    lock_err = lock_err_reg;
  end

endmodule

// File: tb/tb_tr_arbiter.sv
// Directed bench for tr_arbiter. It uses MAX_LOCK=4 so that the lock timeout is reached quickly.
module tb_tr_arbiter;
  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] req;
  logic [4:0] lock;
  logic       err_clr;
  logic [4:0] gnt;
  logic       tr_write;
  logic [2:0] tr_src;
  logic       busy;
  logic       lock_err;

  int checks = 0;
  int errors = 0;

  tr_arbiter #(.MAX_LOCK(4)) dut (
    .CLK(CLK), .reset(reset), .req(req), .lock(lock), .err_clr(err_clr),
    .gnt(gnt), .tr_write(tr_write), .tr_src(tr_src), .busy(busy), .lock_err(lock_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] g, input logic tw,
                            input logic [2:0] src, input logic b, input logic err);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".tr_write"}, 32'(tr_write), 32'(tw));
    check({tag, ".tr_src"}, 32'(tr_src), 32'(src));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".lock_err"}, 32'(lock_err), 32'(err));
    $display("%-12s gnt=%b tr_write=%0d tr_src=%0d busy=%0d lock_err=%0d",
             tag, gnt, tr_write, tr_src, busy, lock_err);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 5'b11111; lock = 5'b0; err_clr = 1'b0;
    tick(); expect_out("reset0", 5'b0, 0, 0, 0, 0);
    tick(); expect_out("reset1", 5'b0, 0, 0, 0, 0);

    reset = 1'b1; req = 5'b0;
    tick(); expect_out("idle", 5'b0, 0, 0, 0, 0);

    // single write from requester c
    req = 5'b00100;
    tick(); expect_out("single", 5'b00100, 1, 2, 1, 0);
    req = 5'b0;
    tick(); expect_out("single_end", 5'b0, 0, 2, 0, 0);

    // round robin from pointer 0
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_out($sformatf("rr%0d", k), 5'(5'b00001 << (k % 5)), 1, 3'(k % 5), 1, 0);
    end
    req = 5'b0;
    tick(); expect_out("rr_idle", 5'b0, 0, 0, 0, 0);

    // lock by requester b, tr_write follows req[1] one cycle late; pointer is now 1
    req = 5'b00010; lock = 5'b00010;
    tick(); expect_out("lk_grant", 5'b00010, 1, 1, 1, 0);
    req = 5'b00011;
    tick(); expect_out("lk_c1", 5'b00010, 1, 1, 1, 0);
    req = 5'b00001;
    tick(); expect_out("lk_c2", 5'b00010, 0, 1, 1, 0);
    req = 5'b00011;
    tick(); expect_out("lk_c3", 5'b00010, 1, 1, 1, 0);
    req = 5'b00001; lock = 5'b0;
    tick(); expect_out("lk_release", 5'b00001, 1, 0, 1, 0);
    req = 5'b0;
    tick(); expect_out("lk_idle", 5'b0, 0, 0, 0, 0);

    // timeout: lock[3] held through 4 LOCKED cycles, then forced release
    req = 5'b01000; lock = 5'b01000;
    tick(); expect_out("to_grant", 5'b01000, 1, 3, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); expect_out($sformatf("to_lock%0d", k), 5'b01000, 1, 3, 1, 0);
    end
    tick(); expect_out("to_forced", 5'b0, 0, 3, 0, 1);
    req = 5'b0;
    tick(); expect_out("to_sticky0", 5'b0, 0, 3, 0, 1);
    tick(); expect_out("to_sticky1", 5'b0, 0, 3, 0, 1);
    err_clr = 1'b1;
    tick(); expect_out("to_clear", 5'b0, 0, 3, 0, 0);
    err_clr = 1'b0; lock = 5'b0;
    tick(); expect_out("to_cleared", 5'b0, 0, 3, 0, 0);

    // reset during the second LOCKED cycle; pointer is 4 here, so requester c wins
    req = 5'b00100; lock = 5'b00100;
    tick(); expect_out("rl_grant", 5'b00100, 1, 2, 1, 0);
    tick(); expect_out("rl_lock1", 5'b00100, 1, 2, 1, 0);
    tick(); expect_out("rl_lock2", 5'b00100, 1, 2, 1, 0);
    reset = 1'b0;
    tick(); expect_out("rl_reset", 5'b0, 0, 0, 0, 0);
    reset = 1'b1; req = 5'b10001; lock = 5'b0;
    tick(); expect_out("rl_first", 5'b00001, 1, 0, 1, 0);
    tick(); expect_out("rl_second", 5'b10000, 1, 4, 1, 0);
    tick(); expect_out("rl_third", 5'b00001, 1, 0, 1, 0);

    // same requester alone: grant, gap, grant
    req = 5'b00001;
    tick(); expect_out("self_gap", 5'b0, 0, 0, 0, 0);
    tick(); expect_out("self_again", 5'b00001, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
